ram_responder: RTL and testbench
================================

// Module: ram_responder
// PURPOSE
//  RAM-side end of the memory-controller/RAM link: consumes ramREN/ramWEN/ramaddr/ramstore, returns ramload/ramstate.
//  Synthesizable word-addressed memory with programmable access latency, stands in for system RAM under memory_control.
//  Per-transaction FSM reports FREE/BUSY/ACCESS/ERROR so the controller's wait/ACCESS arbitration is exercised cycle-accurately.
// PARAMETERS
//  LAT    2     BUSY cycles before ACCESS (0..255); 0 = ACCESS the cycle after the request is accepted
//  DEPTH  1024  number of 32-bit words; word index = ramaddr[31:2]
// PORTS
//  CLK       in   1   clock, rising edge
//  nRST      in   1   reset, synchronous, active-low
//  ramREN    in   1   read request, level, held until ACCESS seen
//  ramWEN    in   1   write request, level, held until ACCESS seen
//  ramaddr   in   32  byte address; bits [1:0] ignored
//  ramstore  in   32  write data, sampled on ACCESS cycle
//  ramload   out  32  read data, valid only while ramstate==ACCESS for a read
//  ramstate  out  2   ramstate_t: FREE, BUSY, ACCESS, ERROR
// BEHAVIOUR
//  Reset: state FREE, cnt 0, latched addr/op 0; ramstate=FREE, ramload=0. Memory contents NOT cleared.
//  ramstate is a decode of the registered state only; ramload is combinational from the array at latched index.
//  FSM (all transitions on rising CLK):
//   FREE  : REN^WEN -> latch addr/op; idx>=DEPTH -> ERROR; else LAT==0 -> ACCESS, else BUSY, cnt=LAT-1.
//           REN&WEN -> ERROR. Neither -> FREE.
//   BUSY  : request dropped -> FREE. addr or op differs from latch -> relatch, restart cnt=LAT-1 (stay BUSY;
//           LAT==0 cannot occur here). cnt==0 -> ACCESS, else cnt--.
//   ACCESS: one cycle. Read: ramload=mem[idx]. Write: mem[idx]<=ramstore at the edge closing this cycle.
//           Next: FREE (re-arbitration; a still-held request starts a fresh transaction from FREE next cycle).
//           Request changed/dropped during ACCESS: commit still uses latched idx/op; write with WEN dropped -> no write.
//   ERROR : ramstate=ERROR, ramload=0, no array access; returns to FREE when REN=WEN=0.
//  Latency: request first seen in FREE at cycle t -> ACCESS in cycle t+LAT+1; back-to-back same-address
//   transactions cost LAT+2 cycles each (FREE gap included).
//  cnt width 8 bits, saturating decrement never wraps. Index compare uses full ramaddr[31:2] (no aliasing).
//  Reset asserted mid-BUSY/ACCESS: to FREE next edge; pending write in ACCESS is discarded (reset wins).
//  ramload outside read-ACCESS driven 0 (never X).
// STRUCTURE
//  Shared: ramstate_t, word_t from cpu_types_pkg; add RAM_LAT_MAX=255 to cpu_types_pkg.
//  Local: state_t {S_FREE,S_BUSY,S_ACCESS,S_ERROR}, decoded onto ramstate_t.
//  Sub-module ram_array: DEPTH x 32, async read, sync write enable (we, widx, wdata, ridx, rdata).
//  Top = FSM + counter + request latch around ram_array.
// TESTING
//  1 LAT=2: WEN, addr 0x40, store 0xDEADBEEF -> BUSY,BUSY,ACCESS; then REN 0x40 -> ACCESS cycle ramload=0xDEADBEEF.
//  2 LAT=0: REN 0x0 held 3 txns -> state seq FREE,ACCESS,FREE,ACCESS,FREE,ACCESS; ramload 0 on FREE cycles.
//  3 LAT=3: REN 0x10, after 1 BUSY addr->0x14 -> 3 further BUSY then ACCESS returns mem[5], not mem[4].
//  4 REN&WEN together -> ERROR, held while asserted; drop both -> FREE; mem unchanged (readback check).
//  5 addr 0x1000 (idx 1024 >= DEPTH) REN -> ERROR, ramload 0; addr 0xFFC -> normal ACCESS.
//  6 WEN 0x8 data 0x12345678, nRST=0 on ACCESS cycle -> FREE, ramload 0; later read 0x8 returns old value.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Types shared across the CPU/memory system.
// Holds the RAM link state encoding, the word type and the RAM latency limit.
package cpu_types_pkg;

  localparam int WORD_W      = 32;
  localparam int RAM_LAT_MAX = 255;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

endpackage

// File: rtl/ram_responder_pkg.sv
// Local state encoding for the RAM responder FSM and its mapping onto the
// ramstate_t values seen by the memory controller.
package ram_responder_pkg;
  import cpu_types_pkg::*;

  typedef logic [1:0] state_t;

  localparam state_t S_FREE   = 2'd0;
  localparam state_t S_BUSY   = 2'd1;
  localparam state_t S_ACCESS = 2'd2;
  localparam state_t S_ERROR  = 2'd3;

  function automatic ramstate_t to_ramstate(input state_t s);
    case (s)
      S_BUSY:   return BUSY;
      S_ACCESS: return ACCESS;
      S_ERROR:  return ERROR;
      default:  return FREE;
    endcase
  endfunction

endpackage

// File: rtl/ram_array.sv
// Word-wide memory array with asynchronous read and synchronous write.
// Contents are intentionally not reset.
module ram_array
  import cpu_types_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] widx,
  input  word_t         wdata,
  input  logic [AW-1:0] ridx,
  output word_t         rdata
);

  word_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[widx] <= wdata;
    end
  end

  assign rdata = mem_q[ridx];

endmodule

// File: rtl/ram_responder.sv
// RAM end of the controller/RAM link: latches a request, waits LAT BUSY
// cycles, then performs a single ACCESS cycle and returns to FREE.
module ram_responder
  import cpu_types_pkg::*;
  import ram_responder_pkg::*;
#(
  parameter int LAT   = 2,
  parameter int DEPTH = 1024
) (
  input  logic      CLK,
  input  logic      nRST,
  input  logic      ramREN,
  input  logic      ramWEN,
  input  word_t     ramaddr,
  input  word_t     ramstore,
  output word_t     ramload,
  output ramstate_t ramstate
);

  localparam int          AW       = $clog2(DEPTH);
  localparam int          LAT_C    = (LAT > RAM_LAT_MAX) ? RAM_LAT_MAX : LAT;
  localparam logic [7:0]  CNT_INIT = (LAT_C == 0) ? 8'd0 : 8'(LAT_C - 1);
  localparam logic [29:0] DEPTH_W  = 30'(DEPTH);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [29:0] idx_q, idx_d;
  logic        op_q, op_d;        // 1 = write

  logic [29:0] req_idx;
  logic        req_one, req_both, req_none;
  logic        mem_we;
  word_t       mem_rdata;
  logic        unused_addr_bits;

  assign req_idx          = ramaddr[31:2];
  assign req_one          = ramREN ^ ramWEN;
  assign req_both         = ramREN & ramWEN;
  assign req_none         = ~(ramREN | ramWEN);
  assign unused_addr_bits = ^ramaddr[1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    op_d    = op_q;
    case (state_q)
      S_FREE: begin
        if (req_both) begin
          state_d = S_ERROR;
        end else if (req_one) begin
          idx_d = req_idx;
          op_d  = ramWEN;
          if (req_idx >= DEPTH_W) begin
            state_d = S_ERROR;
          end else if (LAT_C == 0) begin
            state_d = S_ACCESS;
          end else begin
            state_d = S_BUSY;
            cnt_d   = CNT_INIT;
          end
        end
      end
      S_BUSY: begin
        if (req_none) begin
          state_d = S_FREE;
        end else if (req_both) begin
          state_d = S_ERROR;
        end else if ((req_idx != idx_q) || (ramWEN != op_q)) begin
          // Controller changed its mind mid-wait: restart the latency window.
          idx_d = req_idx;
          op_d  = ramWEN;
          cnt_d = CNT_INIT;
          if (req_idx >= DEPTH_W) begin
            state_d = S_ERROR;
          end
        end else if (cnt_q == 8'd0) begin
          state_d = S_ACCESS;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_ACCESS: state_d = S_FREE;
      S_ERROR: begin
        if (req_none) begin
          state_d = S_FREE;
        end
      end
      default: state_d = S_FREE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= S_FREE;
      cnt_q   <= 8'd0;
      idx_q   <= 30'd0;
      op_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      op_q    <= op_d;
    end
  end

  // Reset on the ACCESS edge discards the write; a dropped WEN cancels it too.
  assign mem_we = (state_q == S_ACCESS) && op_q && ramWEN && nRST;

  ram_array #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_ram_array (
    .clk  (CLK),
    .we   (mem_we),
    .widx (idx_q[AW-1:0]),
    .wdata(ramstore),
    .ridx (idx_q[AW-1:0]),
    .rdata(mem_rdata)
  );

  assign ramload  = ((state_q == S_ACCESS) && !op_q) ? mem_rdata : '0;
  assign ramstate = to_ramstate(state_q);

endmodule

// File: tb/tb_ram_responder.sv
// Bench for ram_responder: three instances (LAT 2, 0, 3) sharing clock and reset,
// read data checked against a scoreboard queue filled when requests are issued.
module tb_ram_responder;
  import cpu_types_pkg::*;

  logic      clk = 1'b0;
  logic      n_rst;
  logic      ren   [3];
  logic      wen   [3];
  word_t     addr  [3];
  word_t     store [3];
  word_t     load  [3];
  ramstate_t st    [3];

  int    n_cmp = 0;
  int    n_bad = 0;
  word_t exp_q[$];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    ram_responder #(
      .LAT  ((gi == 0) ? 2 : (gi == 1) ? 0 : 3),
      .DEPTH(1024)
    ) u_dut (
      .CLK     (clk),
      .nRST    (n_rst),
      .ramREN  (ren[gi]),
      .ramWEN  (wen[gi]),
      .ramaddr (addr[gi]),
      .ramstore(store[gi]),
      .ramload (load[gi]),
      .ramstate(st[gi])
    );
  end

  function automatic int lat_of(input int d);
    return (d == 0) ? 2 : (d == 1) ? 0 : 3;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_state(input string tag, input int d, input ramstate_t e);
    check_val(tag, 32'(st[d]), 32'(e));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int d, input logic r, input logic w, input word_t a, input word_t v);
    ren[d]   = r;
    wen[d]   = w;
    addr[d]  = a;
    store[d] = v;
  endtask

  // One complete transaction: request held through ACCESS, dropped once FREE.
  task automatic do_txn(input int d, input bit wr, input word_t a, input word_t v);
    int    n;
    word_t e;
    n = 0;
    if (!wr) exp_q.push_back(v);
    drive(d, !wr, wr, a, v);
    do begin
      tick();
      n++;
    end while (st[d] != ACCESS && n < 300);
    check_val("access_latency", n, lat_of(d) + 1);
    if (!wr) begin
      e = exp_q.pop_front();
      check_val("read_data", load[d], e);
    end
    tick();
    drive(d, 1'b0, 1'b0, a, v);
    chk_state("post_txn_free", d, FREE);
    check_val("post_txn_load0", load[d], 32'h0);
    $display("txn dut%0d %s addr=%h data=%h cycles=%0d", d, wr ? "WR" : "RD", a, v, n);
  endtask

  initial begin
    word_t e;
    n_rst = 1'b0;
    for (int d = 0; d < 3; d++) drive(d, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    tick();
    for (int d = 0; d < 3; d++) begin
      chk_state("reset_state", d, FREE);
      check_val("reset_load", load[d], 32'h0);
    end
    n_rst = 1'b1;
    tick();

    // Test 1: LAT=2 write then readback
    drive(0, 1'b0, 1'b1, 32'h40, 32'hDEADBEEF);
    tick(); chk_state("t1_busy0", 0, BUSY);
    tick(); chk_state("t1_busy1", 0, BUSY);
    tick(); chk_state("t1_access", 0, ACCESS);
    tick(); chk_state("t1_free", 0, FREE);
    drive(0, 1'b0, 1'b0, 32'h40, 32'h0);
    $display("txn dut0 WR addr=00000040 data=deadbeef (sequence check)");
    do_txn(0, 1'b0, 32'h40, 32'hDEADBEEF);

    // Test 2: LAT=0, read held across three transactions
    do_txn(1, 1'b1, 32'h0, 32'hA5A50001);
    for (int k = 0; k < 3; k++) exp_q.push_back(32'hA5A50001);
    drive(1, 1'b1, 1'b0, 32'h0, 32'h0);
    chk_state("t2_free_start", 1, FREE);
    check_val("t2_load0_start", load[1], 32'h0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_state("t2_access", 1, ACCESS);
      e = exp_q.pop_front();
      check_val("t2_read_data", load[1], e);
      if (k < 2) begin
        tick();
        chk_state("t2_free_gap", 1, FREE);
        check_val("t2_load0_gap", load[1], 32'h0);
      end
    end
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    chk_state("t2_free_end", 1, FREE);
    $display("txn dut1 RD x3 addr=00000000 back-to-back");

    // Test 3: LAT=3, address changes after one BUSY cycle
    do_txn(2, 1'b1, 32'h10, 32'h00000044);
    do_txn(2, 1'b1, 32'h14, 32'h00000055);
    exp_q.push_back(32'h00000055);
    drive(2, 1'b1, 1'b0, 32'h10, 32'h0);
    tick(); chk_state("t3_busy_first", 2, BUSY);
    addr[2] = 32'h14;
    for (int k = 0; k < 3; k++) begin
      tick(); chk_state("t3_busy_restart", 2, BUSY);
    end
    tick(); chk_state("t3_access", 2, ACCESS);
    e = exp_q.pop_front();
    check_val("t3_read_data", load[2], e);
    drive(2, 1'b0, 1'b0, 32'h14, 32'h0);
    tick(); chk_state("t3_free", 2, FREE);
    $display("txn dut2 RD addr=00000010->00000014 relatch");

    // Test 4: REN and WEN together
    drive(0, 1'b1, 1'b1, 32'h40, 32'hBAD0BAD0);
    tick(); chk_state("t4_error", 0, ERROR);
    check_val("t4_load0", load[0], 32'h0);
    tick(); chk_state("t4_error_held", 0, ERROR);
    drive(0, 1'b0, 1'b0, 32'h40, 32'h0);
    tick(); chk_state("t4_free", 0, FREE);
    $display("txn dut0 RD+WR addr=00000040 error");
    do_txn(0, 1'b0, 32'h40, 32'hDEADBEEF);

    // Test 5: out-of-range index, then the last valid word
    drive(0, 1'b1, 1'b0, 32'h1000, 32'h0);
    tick(); chk_state("t5_oob_error", 0, ERROR);
    check_val("t5_oob_load0", load[0], 32'h0);
    drive(0, 1'b0, 1'b0, 32'h1000, 32'h0);
    tick(); chk_state("t5_free", 0, FREE);
    $display("txn dut0 RD addr=00001000 out of range");
    do_txn(0, 1'b1, 32'hFFC, 32'hCAFEF00D);
    do_txn(0, 1'b0, 32'hFFC, 32'hCAFEF00D);

    // Test 6: reset during the ACCESS cycle of a write
    do_txn(0, 1'b1, 32'h8, 32'h11112222);
    drive(0, 1'b0, 1'b1, 32'h8, 32'h12345678);
    tick(); tick();
    tick(); chk_state("t6_access", 0, ACCESS);
    n_rst = 1'b0;
    tick(); chk_state("t6_reset_free", 0, FREE);
    check_val("t6_reset_load0", load[0], 32'h0);
    n_rst = 1'b1;
    drive(0, 1'b0, 1'b0, 32'h8, 32'h0);
    tick(); chk_state("t6_free_after", 0, FREE);
    $display("txn dut0 WR addr=00000008 data=12345678 aborted by reset");
    do_txn(0, 1'b0, 32'h8, 32'h11112222);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
